activation_sequencer: RTL and testbench

//  Sequences the ReLU activation stage of the TTPU. On start it reads num_rows

---
 rtl/ttpu_pkg.sv | 23 ++
 rtl/act_pipe_ctrl.sv | 49 ++++
 rtl/activation_sequencer.sv | 125 ++++++++++++
 tb/tb_activation_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ttpu_pkg.sv
// ============================================================================
// Module : ttpu_pkg
// Brief  : Shared types and default sizes for the TTPU activation stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ttpu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_LENGTH     = 32;
    localparam int DEFAULT_ADDR_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } act_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/act_pipe_ctrl.sv
// ============================================================================
// Module : act_pipe_ctrl
// Brief  : Two-slot valid pipeline (acc read data, ReLU output) with stall.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module act_pipe_ctrl (
    input  logic clk,
    input  logic reset,
    input  logic i_issue_req,
    input  logic i_ub_wr_ready,
    output logic o_issue,
    output logic o_act_en,
    output logic o_wr_en,
    output logic o_wr_accept,
    output logic o_v1,
    output logic o_v2
);

    logic r_v1;
    logic r_v2;
    logic w_stall;
    logic w_issue;

    // A pending write that the buffer refuses freezes the whole pipeline.
    assign w_stall     = r_v2 & ~i_ub_wr_ready;
    assign w_issue     = i_issue_req & ~w_stall;

    assign o_issue     = w_issue;
    assign o_act_en    = r_v1 & ~w_stall;
    assign o_wr_en     = r_v2;
    assign o_wr_accept = r_v2 & i_ub_wr_ready;
    assign o_v1        = r_v1;
    assign o_v2        = r_v2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else if (!w_stall) begin
            r_v2 <= r_v1;
            r_v1 <= w_issue;
        end
    end

endmodule

`default_nettype wire

// File: rtl/activation_sequencer.sv
// ============================================================================
// Module : activation_sequencer
// Brief  : Streams rows accumulator -> ReLU -> unified buffer for one command.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module activation_sequencer
    import ttpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LENGTH     = DEFAULT_LENGTH,
    parameter int ADDR_W     = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_rows,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              acc_rd_en,
    output logic [ADDR_W-1:0] acc_rd_addr,
    output logic              act_en,
    output logic              ub_wr_en,
    output logic [ADDR_W-1:0] ub_wr_addr,
    input  logic              ub_wr_ready,
    output logic              busy,
    output logic              done
);

    if (DATA_WIDTH < 1 || LENGTH < 1 || ADDR_W < 1) begin : g_bad_param
        $error("activation_sequencer: DATA_WIDTH, LENGTH and ADDR_W must be positive");
    end

    act_seq_state_t    r_state;
    logic [ADDR_W-1:0] r_num_rows;
    logic [ADDR_W-1:0] r_src_base;
    logic [ADDR_W-1:0] r_dst_base;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [ADDR_W-1:0] r_wr_cnt;

    logic w_issue_req;
    logic w_issue;
    logic w_wr_accept;
    logic w_v1;
    logic w_v2;
    logic w_last_issue;
    logic w_drain_empty;

    assign w_issue_req = (r_state == RUN) && (r_rd_cnt < r_num_rows);

    act_pipe_ctrl u_pipe (
        .clk           (clk),
        .reset         (reset),
        .i_issue_req   (w_issue_req),
        .i_ub_wr_ready (ub_wr_ready),
        .o_issue       (w_issue),
        .o_act_en      (act_en),
        .o_wr_en       (ub_wr_en),
        .o_wr_accept   (w_wr_accept),
        .o_v1          (w_v1),
        .o_v2          (w_v2)
    );

    // Leaving RUN on the final issue (not one cycle later) keeps done at N+3.
    assign w_last_issue  = w_issue && (ADDR_W'(r_rd_cnt + 1'b1) == r_num_rows);
    // Pipeline will be empty after this edge: no read in flight, last write taken.
    assign w_drain_empty = !w_v1 && (!w_v2 || ub_wr_ready);

    assign acc_rd_en   = w_issue;
    assign acc_rd_addr = r_src_base + r_rd_cnt;
    assign ub_wr_addr  = r_dst_base + r_wr_cnt;
    assign busy        = (r_state == RUN) || (r_state == DRAIN);
    assign done        = (r_state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_num_rows <= '0;
            r_src_base <= '0;
            r_dst_base <= '0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
        end else begin
            if (w_issue) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_wr_accept) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_num_rows <= num_rows;
                        r_src_base <= src_base;
                        r_dst_base <= dst_base;
                        r_rd_cnt   <= '0;
                        r_wr_cnt   <= '0;
                        r_state    <= (num_rows == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_last_issue || (r_rd_cnt == r_num_rows)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_drain_empty) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_activation_sequencer.sv
// ============================================================================
// Module : tb_activation_sequencer
// Brief  : Randomized self-checking bench with accumulator/ReLU environment.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_activation_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] num_rows;
    logic [7:0] src_base;
    logic [7:0] dst_base;
    logic       acc_rd_en;
    logic [7:0] acc_rd_addr;
    logic       act_en;
    logic       ub_wr_en;
    logic [7:0] ub_wr_addr;
    logic       ub_wr_ready;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fails  = 0;

    logic [15:0] mem [256];
    logic [15:0] acc_data;
    logic [15:0] relu_out;

    activation_sequencer #(
        .DATA_WIDTH (16),
        .LENGTH     (32),
        .ADDR_W     (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_rows    (num_rows),
        .src_base    (src_base),
        .dst_base    (dst_base),
        .acc_rd_en   (acc_rd_en),
        .acc_rd_addr (acc_rd_addr),
        .act_en      (act_en),
        .ub_wr_en    (ub_wr_en),
        .ub_wr_addr  (ub_wr_addr),
        .ub_wr_ready (ub_wr_ready),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: accumulator holds data unless read; ReLU registers on en.
    always @(posedge clk) begin
        if (acc_rd_en) acc_data <= mem[acc_rd_addr];
        if (act_en)    relu_out <= acc_data[15] ? 16'h0000 : acc_data;
    end

    function automatic int relu_ref(input logic [15:0] x);
        return x[15] ? 0 : int'(x);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_rd"},   32'(acc_rd_en), 0);
        check_eq({tag, "_wr"},   32'(ub_wr_en),  0);
        check_eq({tag, "_busy"}, 32'(busy),      0);
        check_eq({tag, "_done"}, 32'(done),      0);
    endtask

    // mode 0: ready always 1; mode 1: random ready; mode 2: ready low cycles 4..6
    task automatic run_cmd(input int n, input int src, input int dst, input int mode,
                           input bit restart);
        int  rd_addr[$];
        int  rd_cyc[$];
        int  wr_addr[$];
        int  wr_data[$];
        int  wr_cyc[$];
        int  done_cyc   = -1;
        int  cyc        = 0;
        int  budget     = n + 60;
        bit  prev_stall = 0;
        int  prev_addr  = 0;
        while (cyc < budget && done_cyc < 0) begin
            start = (cyc == 0) || (restart && cyc == 2);
            if (cyc == 0) begin
                num_rows = 8'(n);
                src_base = 8'(src);
                dst_base = 8'(dst);
            end else begin
                num_rows = 8'($urandom_range(1, 255));
                src_base = 8'($urandom);
                dst_base = 8'($urandom);
            end
            case (mode)
                0:       ub_wr_ready = 1'b1;
                1:       ub_wr_ready = ($urandom_range(0, 3) != 0);
                default: ub_wr_ready = !(cyc >= 4 && cyc <= 6);
            endcase
            @(negedge clk);
            if (prev_stall) begin
                check_eq("stall_hold_wr_en",   32'(ub_wr_en),   1);
                check_eq("stall_hold_wr_addr", 32'(ub_wr_addr), 32'(prev_addr));
            end
            prev_stall = ub_wr_en && !ub_wr_ready;
            if (prev_stall) begin
                check_eq("stall_act_en", 32'(act_en),    0);
                check_eq("stall_rd_en",  32'(acc_rd_en), 0);
                prev_addr = int'(ub_wr_addr);
            end
            check_eq("busy_done_excl", 32'(busy & done), 0);
            if (cyc == 0) check_eq("busy_cyc0", 32'(busy), 0);
            if (mode == 0)
                check_eq("busy_window", 32'(busy), 32'((n > 0) && cyc >= 1 && cyc <= n + 2));
            if (acc_rd_en) begin
                rd_addr.push_back(int'(acc_rd_addr));
                rd_cyc.push_back(cyc);
            end
            if (ub_wr_en && ub_wr_ready) begin
                wr_addr.push_back(int'(ub_wr_addr));
                wr_data.push_back(int'(relu_out));
                wr_cyc.push_back(cyc);
            end
            if (done) done_cyc = cyc;
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check_eq("done_seen",  32'(done_cyc >= 0), 1);
        check_eq("read_count", 32'(rd_addr.size()), 32'(n));
        check_eq("write_count", 32'(wr_addr.size()), 32'(n));
        for (int i = 0; i < n && i < rd_addr.size(); i++)
            check_eq("rd_addr", 32'(rd_addr[i]), 32'((src + i) & 255));
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check_eq("wr_addr", 32'(wr_addr[i]), 32'((dst + i) & 255));
            check_eq("wr_data", 32'(wr_data[i]), 32'(relu_ref(mem[(src + i) & 255])));
        end
        if (mode == 0) begin
            for (int i = 0; i < rd_cyc.size(); i++)
                check_eq("rd_cycle", 32'(rd_cyc[i]), 32'(1 + i));
            for (int i = 0; i < wr_cyc.size(); i++)
                check_eq("wr_cycle", 32'(wr_cyc[i]), 32'(3 + i));
            check_eq("done_cycle", 32'(done_cyc), (n == 0) ? 32'd1 : 32'(n + 3));
        end
        repeat (2) begin
            @(negedge clk);
            check_quiet("post_idle");
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        num_rows    = '0;
        src_base    = '0;
        dst_base    = '0;
        ub_wr_ready = 1'b1;
        acc_data    = '0;
        relu_out    = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        check_eq("reset_rd_addr", 32'(acc_rd_addr), 0);
        check_eq("reset_wr_addr", 32'(ub_wr_addr),  0);
        check_eq("reset_act_en",  32'(act_en),      0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // T1: basic timing
        run_cmd(4, 'h10, 'h80, 0, 0);
        // T2: ReLU data patterns
        mem['h20] = 16'h7FFF;
        mem['h21] = 16'h8000;
        mem['h22] = 16'hFFFF;
        mem['h23] = 16'h0001;
        run_cmd(4, 'h20, 'h40, 0, 0);
        // T3: scripted stall on row 1
        run_cmd(4, 'h30, 'h90, 2, 0);
        // T4: zero rows
        run_cmd(0, 'h55, 'h66, 0, 0);
        // T6: start while busy is ignored
        run_cmd(6, 'h04, 'hA0, 0, 1);
        // T7: source and destination wrap
        run_cmd(4, 'hFE, 'hFD, 0, 0);

        // T5: reset in the middle of an 8-row command
        start    = 1'b1;
        num_rows = 8'd8;
        src_base = 8'h60;
        dst_base = 8'h70;
        ub_wr_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_quiet("mid_reset");
            check_eq("mid_reset_act_en",  32'(act_en),      0);
            check_eq("mid_reset_rd_addr", 32'(acc_rd_addr), 0);
            check_eq("mid_reset_wr_addr", 32'(ub_wr_addr),  0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_quiet("after_reset");
            @(posedge clk);
            #1;
        end
        run_cmd(5, 'h60, 'h70, 0, 0);

        // Randomized commands with random backpressure
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
            run_cmd($urandom_range(0, 20), $urandom_range(0, 255), $urandom_range(0, 255),
                    1, ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
